wait_state_ram: RTL and testbench
=================================

// Module: wait_state_ram
// PURPOSE
//  Word-organised on-chip RAM with programmable access latency, sitting directly downstream of the
//  memory controller's memory port. Accepts one read or write per request, stalls for WAIT_CYCLES,
//  then pulses mem_ready with read data held stable. Serves as instruction/data store for sim and FPGA.
// PARAMETERS
//  DEPTH        1024   number of 32-bit words; byte address range 0 .. DEPTH*4-1
//  WAIT_CYCLES  2      extra stall cycles between request acceptance and the ready cycle (0 allowed)
//  INIT_FILE    ""     hex image loaded with $readmemh at elaboration; empty = contents undefined
// PORTS
//  clk             in   1   system clock, all logic on rising edge
//  reset           in   1   synchronous, active-high reset
//  mem_addr        in   32  byte address; bits [1:0] ignored (word access only)
//  mem_write_data  in   32  write data
//  mem_read_en     in   1   read request, level, sampled only in IDLE
//  mem_write_en    in   1   write request, level, sampled only in IDLE; wins if both enables high
//  mem_read_data   out  32  read data; valid in ready cycle, held until next read completes
//  mem_ready       out  1   one-cycle completion pulse for the accepted access
//  oor_access      out  1   one-cycle pulse coincident with mem_ready when the access was out of range
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: state=IDLE, mem_ready=0, oor_access=0, mem_read_data=0, wait counter=0. RAM array is not reset.
//  FSM:
//   IDLE: if mem_write_en|mem_read_en -> latch addr, wdata, is_write; cnt<=WAIT_CYCLES;
//         go BUSY (WAIT_CYCLES>0) or RESP (WAIT_CYCLES==0). Else stay.
//   BUSY: cnt decrements each cycle; when cnt==1 -> RESP. Port inputs are ignored (latched values used).
//   RESP: mem_ready=1 (registered, exactly one cycle); next state is IDLE unconditionally.
//  Latency: request first seen high in cycle N -> mem_ready high in cycle N+WAIT_CYCLES+1.
//  Commit: write array / capture read data on the edge that enters RESP, so data is valid while mem_ready=1.
//  Back-to-back: the IDLE cycle after RESP is mandatory; the controller drops its enables in that cycle.
//   If enables are still high there, a new access is accepted (no de-dup; that is upstream's job).
//  Out of range (mem_addr >= DEPTH*4): write dropped; read returns 32'h0; latency unchanged; oor_access=1 with mem_ready.
//  Enables dropping during BUSY: the access still completes and mem_ready still pulses; no abort.
//  Read data: mem_read_data updates only on completed reads; writes leave it unchanged.
//  Reset mid-access: the access is abandoned. A pending write is not committed, and mem_ready is 0 next cycle.
//  Index width: $clog2(DEPTH) bits from mem_addr[$clog2(DEPTH)+1:2]; counter width $clog2(WAIT_CYCLES+1), min 1.
// STRUCTURE
//  mem_pkg: FSM state localparams (IDLE/BUSY/RESP, 2-bit), WORD_BYTES=4, OOR_READ_DATA=32'h0.
//  Sub-module sync_ram_1rw (DEPTH, INIT_FILE): single-port array, synchronous write, registered read,
//  one clock enable. wait_state_ram contains only the FSM, counter, latches and range check.
// TESTING
//  1 WAIT=2: write 0x0000_0010 <- 0xCAFE_F00D, then read 0x10 -> ready 3 cycles after each request; read data 0xCAFE_F00D.
//  2 WAIT=0: read 0x4 -> mem_ready in the next cycle; read_en held high through IDLE -> second access accepted, ready 2 cycles later.
//  3 DEPTH=1024: write 0x1000 <- 0x1234 -> oor_access=1 with ready; read 0x0 still returns its prior value; read 0x1000 -> 0x0.
//  4 Both enables high, addr 0x8, wdata 0xA5A5_A5A5 -> treated as write; a later read of 0x8 returns 0xA5A5_A5A5.
//  5 Enables dropped in the 1st BUSY cycle (WAIT=3) -> ready still asserts 4 cycles after the request; write committed.
//  6 Reset asserted in BUSY of a write to 0x20 (prior 0x1111) -> mem_ready=0 next cycle; read 0x20 -> 0x1111.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the wait-state RAM and its backing array.
package mem_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WORD_BYTES = 4;

  localparam logic [DATA_W-1:0] OOR_READ_DATA = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/sync_ram_1rw.sv
// Single-port word array: synchronous write, registered read, one clock enable.
module sync_ram_1rw
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter string       INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  // Read register only moves on an enabled read, so it holds across writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/wait_state_ram.sv
// Word RAM with programmable access latency: accept, stall WAIT_CYCLES, then pulse mem_ready.
module wait_state_ram
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_write_data,
  input  logic              mem_read_en,
  input  logic              mem_write_en,
  output logic [DATA_W-1:0] mem_read_data,
  output logic              mem_ready,
  output logic              oor_access
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH * WORD_BYTES);

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic              oor_q;
  logic              oor_rd_q;

  logic              req;
  logic              live_oor;
  logic              accept;
  logic              commit;
  logic [IDX_W-1:0]  sel_idx;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_write;
  logic              sel_oor;
  logic [DATA_W-1:0] ram_rdata;

  assign req      = mem_read_en | mem_write_en;
  assign live_oor = (mem_addr >= ADDR_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = (WAIT_CYCLES == 0) ? RESP : BUSY;
      BUSY:    if (cnt_q == CNT_W'(1)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait the commit happens on the accepting edge, so IDLE steers live port values.
  always_comb begin
    sel_idx   = idx_q;
    sel_wdata = wdata_q;
    sel_write = write_q;
    sel_oor   = oor_q;
    accept    = 1'b0;
    if (state_q == IDLE) begin
      sel_idx   = mem_addr[IDX_W+1:2];
      sel_wdata = mem_write_data;
      sel_write = mem_write_en;
      sel_oor   = live_oor;
      accept    = req;
    end
    commit = (state_d == RESP) && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      oor_q      <= 1'b0;
      oor_rd_q   <= 1'b0;
      mem_ready  <= 1'b0;
      oor_access <= 1'b0;
    end else begin
      mem_ready  <= commit;
      oor_access <= commit & sel_oor;
      if (accept) begin
        cnt_q   <= CNT_W'(WAIT_CYCLES);
        idx_q   <= sel_idx;
        wdata_q <= sel_wdata;
        write_q <= sel_write;
        oor_q   <= sel_oor;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (commit && !sel_write) oor_rd_q <= sel_oor;
    end
  end

  sync_ram_1rw #(
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .en    (commit && !sel_oor),
    .we    (sel_write),
    .addr  (sel_idx),
    .wdata (sel_wdata),
    .rdata (ram_rdata)
  );

  // Out-of-range reads return a fixed word; in-range reads show the held RAM read register.
  assign mem_read_data = oor_rd_q ? OOR_READ_DATA : ram_rdata;

endmodule

// File: tb/tb_wait_state_ram.sv
// Directed bench: three instances (WAIT_CYCLES = 2, 0, 3) driven through one access task.
module tb_wait_state_ram;

  logic clk = 1'b0;
  logic reset;

  logic [2:0]       re, we, rdy, oor;
  logic [2:0][31:0] addr, wdata, rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wait_state_ram #(.DEPTH(1024), .WAIT_CYCLES(2), .INIT_FILE("")) dut_w2 (
    .clk(clk), .reset(reset), .mem_addr(addr[0]), .mem_write_data(wdata[0]),
    .mem_read_en(re[0]), .mem_write_en(we[0]), .mem_read_data(rdata[0]),
    .mem_ready(rdy[0]), .oor_access(oor[0]));

  wait_state_ram #(.DEPTH(1024), .WAIT_CYCLES(0), .INIT_FILE("")) dut_w0 (
    .clk(clk), .reset(reset), .mem_addr(addr[1]), .mem_write_data(wdata[1]),
    .mem_read_en(re[1]), .mem_write_en(we[1]), .mem_read_data(rdata[1]),
    .mem_ready(rdy[1]), .oor_access(oor[1]));

  wait_state_ram #(.DEPTH(1024), .WAIT_CYCLES(3), .INIT_FILE("")) dut_w3 (
    .clk(clk), .reset(reset), .mem_addr(addr[2]), .mem_write_data(wdata[2]),
    .mem_read_en(re[2]), .mem_write_en(we[2]), .mem_read_data(rdata[2]),
    .mem_ready(rdy[2]), .oor_access(oor[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on instance k; ready must appear exactly lat cycles after the request cycle.
  // Enables drop and addr/wdata are scrambled right after acceptance to prove latching.
  task automatic access(input int k, input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d, input int lat,
                        output logic [31:0] rd_o, output logic oor_o);
    @(negedge clk);
    we[k] = w; re[k] = r; addr[k] = a; wdata[k] = d;
    rd_o = '0; oor_o = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      if (i == 1) begin
        we[k] = 1'b0; re[k] = 1'b0; addr[k] = ~a; wdata[k] = ~d;
      end
      if (i < lat) begin
        chk($sformatf("inst%0d addr%h ready early c%0d", k, a, i), 32'(rdy[k]), 32'h0);
      end else begin
        chk($sformatf("inst%0d addr%h ready", k, a), 32'(rdy[k]), 32'h1);
        rd_o  = rdata[k];
        oor_o = oor[k];
      end
    end
    @(negedge clk);
    chk($sformatf("inst%0d addr%h ready pulse width", k, a), 32'(rdy[k]), 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        ob;

    reset = 1'b1;
    re = '0; we = '0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset ready inst%0d", k), 32'(rdy[k]), 32'h0);
      chk($sformatf("reset oor inst%0d", k), 32'(oor[k]), 32'h0);
      chk($sformatf("reset rdata inst%0d", k), rdata[k], 32'h0);
    end
    reset = 1'b0;

    // WAIT=2 write then read back
    access(0, 1'b1, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, 3, rd, ob);
    chk("t1 write oor", 32'(ob), 32'h0);
    chk("t1 write leaves rdata", rd, 32'h0);
    access(0, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 3, rd, ob);
    chk("t1 read data", rd, 32'hCAFE_F00D);
    chk("t1 read oor", 32'(ob), 32'h0);
    chk("t1 rdata held after ready", rdata[0], 32'hCAFE_F00D);

    // WAIT=0: single access, then read_en held through the mandatory IDLE cycle
    access(1, 1'b1, 1'b0, 32'h0000_0004, 32'h4444_0004, 1, rd, ob);
    @(negedge clk);
    re[1] = 1'b1; addr[1] = 32'h0000_0004;
    @(negedge clk);
    chk("t2 ready next cycle", 32'(rdy[1]), 32'h1);
    chk("t2 read data", rdata[1], 32'h4444_0004);
    @(negedge clk);
    chk("t2 idle gap", 32'(rdy[1]), 32'h0);
    @(negedge clk);
    chk("t2 second ready", 32'(rdy[1]), 32'h1);
    chk("t2 second data", rdata[1], 32'h4444_0004);
    re[1] = 1'b0;
    @(negedge clk);
    chk("t2 second pulse width", 32'(rdy[1]), 32'h0);

    // Out of range: write dropped (must not alias onto word 0), read returns zero
    access(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0A0A, 3, rd, ob);
    access(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_1234, 3, rd, ob);
    chk("t3 oor write flag", 32'(ob), 32'h1);
    chk("t3 oor write leaves rdata", rd, 32'hCAFE_F00D);
    chk("t3 oor flag one cycle", 32'(oor[0]), 32'h0);
    access(0, 1'b0, 1'b1, 32'h0000_0000, 32'h0, 3, rd, ob);
    chk("t3 word0 intact", rd, 32'h0000_0A0A);
    chk("t3 word0 in range", 32'(ob), 32'h0);
    access(0, 1'b0, 1'b1, 32'h0000_1000, 32'h0, 3, rd, ob);
    chk("t3 oor read data", rd, 32'h0);
    chk("t3 oor read flag", 32'(ob), 32'h1);
    access(0, 1'b0, 1'b1, 32'h0000_0FFC, 32'h0, 3, rd, ob);
    chk("t3 last word in range", 32'(ob), 32'h0);

    // Both enables: write wins
    access(0, 1'b1, 1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 3, rd, ob);
    chk("t4 both enables leave rdata", rdata[0], rd);
    access(0, 1'b0, 1'b1, 32'h0000_0008, 32'h0, 3, rd, ob);
    chk("t4 read back", rd, 32'hA5A5_A5A5);

    // WAIT=3: enables dropped in first BUSY cycle, write still commits
    access(2, 1'b1, 1'b0, 32'h0000_0030, 32'h3333_0030, 4, rd, ob);
    access(2, 1'b0, 1'b1, 32'h0000_0030, 32'h0, 4, rd, ob);
    chk("t5 write committed", rd, 32'h3333_0030);

    // Reset in BUSY abandons the pending write
    access(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_1111, 3, rd, ob);
    @(negedge clk);
    we[0] = 1'b1; addr[0] = 32'h0000_0020; wdata[0] = 32'h0000_2222;
    @(negedge clk);
    we[0] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6 ready after reset", 32'(rdy[0]), 32'h0);
    chk("t6 rdata after reset", rdata[0], 32'h0);
    @(negedge clk);
    chk("t6 no late ready", 32'(rdy[0]), 32'h0);
    access(0, 1'b0, 1'b1, 32'h0000_0020, 32'h0, 3, rd, ob);
    chk("t6 write abandoned", rd, 32'h0000_1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
